// File: rtl/lc3_mem_ctrl_if.sv
// Memory-side bus of the LC-3 memory-interface stage.
// The controller drives the request side; the external memory drives rdata/ack.
interface lc3_mem_ctrl_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-interface stage: owns MAR/MDR and turns control-unit memory enables
// into a req/ack transaction with wait-state timeout, pulsing memRDY on completion.
module lc3_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Buss,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memEN,
    input  logic        memWE,
    input  logic        enaMDR,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] MDRBus,
    output logic        memRDY,
    output logic        memErr,
    lc3_mem_ctrl_if.master mem
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        DONE
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       req_q;
    logic       we_q;

    // Address and write data come straight from the registers; neither can change
    // while a request is outstanding because loads are only honoured in IDLE.
    assign mem.mem_addr  = MAR;
    assign mem.mem_wdata = MDR;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;

    assign MDRBus = enaMDR ? MDR : 16'h0000;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            MAR      <= 16'h0000;
            MDR      <= 16'h0000;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            memRDY   <= 1'b0;
            memErr   <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            memRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ldMAR) begin
                        MAR <= Buss;
                    end
                    if (ldMDR && !selMDR) begin
                        MDR <= Buss;
                    end
                    if (memEN) begin
                        req_q    <= 1'b1;
                        we_q     <= memWE;
                        wait_cnt <= 8'd0;
                        state    <= memWE ? WR_WAIT : RD_WAIT;
                    end
                end

                RD_WAIT, WR_WAIT: begin
                    // An ack on the final wait cycle still completes normally.
                    if (mem.mem_ack) begin
                        if (state == RD_WAIT) begin
                            MDR <= mem.mem_rdata;
                        end
                        req_q  <= 1'b0;
                        we_q   <= 1'b0;
                        memRDY <= 1'b1;
                        state  <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        if (state == RD_WAIT) begin
                            MDR <= 16'h0000;
                        end
                        memErr <= 1'b1;
                        req_q  <= 1'b0;
                        we_q   <= 1'b0;
                        memRDY <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                DONE: begin
                    wait_cnt <= 8'd0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed cases followed by randomized
// transactions scored against a transaction-level model of MAR/MDR/memErr.
module tb_lc3_mem_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] Buss = 16'h0000;
    logic        ldMAR = 1'b0;
    logic        ldMDR = 1'b0;
    logic        selMDR = 1'b0;
    logic        memEN = 1'b0;
    logic        memWE = 1'b0;
    logic        enaMDR = 1'b0;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] MDRBus;
    logic        memRDY;
    logic        memErr;

    lc3_mem_ctrl_if bus ();

    lc3_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .Buss   (Buss),
        .ldMAR  (ldMAR),
        .ldMDR  (ldMDR),
        .selMDR (selMDR),
        .memEN  (memEN),
        .memWE  (memWE),
        .enaMDR (enaMDR),
        .MAR    (MAR),
        .MDR    (MDR),
        .MDRBus (MDRBus),
        .memRDY (memRDY),
        .memErr (memErr),
        .mem    (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the registers must hold between transactions.
    logic [15:0] m_mar = 16'h0000;
    logic [15:0] m_mdr = 16'h0000;
    logic        m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_regs(input logic [15:0] a, input logic [15:0] d);
        Buss  = a;
        ldMAR = 1'b1;
        tick();
        ldMAR  = 1'b0;
        Buss   = d;
        ldMDR  = 1'b1;
        selMDR = 1'b0;
        tick();
        ldMDR = 1'b0;
        m_mar = a;
        m_mdr = d;
        check("load_mar", MAR, m_mar);
        check("load_mdr", MDR, m_mdr);
    endtask

    task automatic check_mdrbus(input logic ena);
        enaMDR = ena;
        #1;
        check("mdrbus", MDRBus, ena ? m_mdr : 16'h0000);
        enaMDR = 1'b0;
    endtask

    // Runs one transaction. The memory acks after `waits` idle wait cycles; any
    // waits >= TIMEOUT means it never acks. With `disturb` set, loads and memEN are
    // thrown at the block during the wait and must be ignored.
    task automatic run_txn(input string tag, input logic we, input int waits,
                           input logic [15:0] rdata, input logic disturb);
        int n;
        int exp_n;
        logic ok;
        n = 0;
        ok = (waits < TIMEOUT);
        exp_n = ok ? waits + 1 : TIMEOUT;
        memEN = 1'b1;
        memWE = we;
        tick();
        memEN = 1'b0;
        memWE = 1'b0;
        check({tag, "_req_start"}, bus.mem_req, 1'b1);
        check({tag, "_we"}, bus.mem_we, we);
        check({tag, "_addr"}, bus.mem_addr, m_mar);
        check({tag, "_wdata"}, bus.mem_wdata, m_mdr);
        while (1) begin
            bus.mem_ack   = (n == waits);
            bus.mem_rdata = (n == waits) ? rdata : 16'($urandom);
            if (disturb) begin
                Buss   = 16'hFFFF;
                ldMAR  = 1'b1;
                ldMDR  = 1'b1;
                selMDR = 1'b0;
                memEN  = 1'b1;
                memWE  = ~we;
            end
            tick();
            n++;
            bus.mem_ack = 1'b0;
            if (!bus.mem_req || n > TIMEOUT + 4) break;
            check({tag, "_addr_hold"}, bus.mem_addr, m_mar);
            check({tag, "_wdata_hold"}, bus.mem_wdata, m_mdr);
            check({tag, "_rdy_early"}, memRDY, 1'b0);
        end
        ldMAR = 1'b0;
        ldMDR = 1'b0;
        memEN = 1'b0;
        memWE = 1'b0;
        if (ok) begin
            if (!we) m_mdr = rdata;
        end else begin
            if (!we) m_mdr = 16'h0000;
            m_err = 1'b1;
        end
        check({tag, "_req_cycles"}, n, exp_n);
        check({tag, "_rdy"}, memRDY, 1'b1);
        check({tag, "_mdr"}, MDR, m_mdr);
        check({tag, "_mar"}, MAR, m_mar);
        check({tag, "_err"}, memErr, m_err);
        tick();
        check({tag, "_rdy_pulse"}, memRDY, 1'b0);
        check({tag, "_req_idle"}, bus.mem_req, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;

        // Reset state.
        tick();
        check("rst_mar", MAR, 16'h0000);
        check("rst_mdr", MDR, 16'h0000);
        check("rst_req", bus.mem_req, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_rdy", memRDY, 1'b0);
        check("rst_err", memErr, 1'b0);
        rst = 1'b1;
        tick();

        // Read with zero wait states.
        load_regs(16'h3000, 16'h0000);
        run_txn("rd0", 1'b0, 0, 16'hBEEF, 1'b0);
        check("rd0_value", MDR, 16'hBEEF);
        check_mdrbus(1'b1);
        check_mdrbus(1'b0);

        // Write with five wait states.
        load_regs(16'h0040, 16'h1234);
        run_txn("wr5", 1'b1, 5, 16'hDEAD, 1'b0);
        check("wr5_mdr_kept", MDR, 16'h1234);

        // ldMDR with selMDR=1 in IDLE must not load from Buss.
        Buss   = 16'hA5A5;
        ldMDR  = 1'b1;
        selMDR = 1'b1;
        tick();
        ldMDR  = 1'b0;
        selMDR = 1'b0;
        check("sel_mem_noload", MDR, m_mdr);

        // Ack arriving on the last wait cycle wins over the timeout.
        load_regs(16'h0100, 16'h5555);
        run_txn("ack_last", 1'b0, TIMEOUT - 1, 16'h00FF, 1'b0);
        check("ack_last_err", memErr, 1'b0);

        // Loads and memEN during RD_WAIT are ignored.
        load_regs(16'h0200, 16'h7777);
        run_txn("ignore", 1'b0, 4, 16'h4321, 1'b1);
        check("ignore_mar", MAR, 16'h0200);

        // Read timeout, then a good read: memErr stays set.
        load_regs(16'h0300, 16'h9999);
        run_txn("tmo", 1'b0, TIMEOUT + 2, 16'h0000, 1'b0);
        check("tmo_mdr", MDR, 16'h0000);
        check("tmo_err", memErr, 1'b1);
        load_regs(16'h0304, 16'h0000);
        run_txn("after_tmo", 1'b0, 2, 16'hCAFE, 1'b0);
        check("err_sticky", memErr, 1'b1);

        // Reset in the middle of a read.
        load_regs(16'h0400, 16'h1111);
        memEN = 1'b1;
        tick();
        memEN = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("rmid_req", bus.mem_req, 1'b0);
        check("rmid_mar", MAR, 16'h0000);
        check("rmid_mdr", MDR, 16'h0000);
        check("rmid_err", memErr, 1'b0);
        tick();
        rst = 1'b1;
        m_mar = 16'h0000;
        m_mdr = 16'h0000;
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = 1'b1;
            tick();
            check("rmid_no_rdy", memRDY, 1'b0);
            check("rmid_no_req", bus.mem_req, 1'b0);
        end
        bus.mem_ack = 1'b0;
        check("rmid_mdr_after", MDR, 16'h0000);

        // Randomized transactions against the model.
        for (int i = 0; i < 24; i++) begin
            logic        r_we;
            int          r_waits;
            logic [15:0] r_rdata;
            logic        r_dist;
            r_we    = 1'($urandom_range(0, 1));
            r_waits = ($urandom_range(0, 5) == 0) ? TIMEOUT + 2
                                                  : int'($urandom_range(0, TIMEOUT - 1));
            r_rdata = 16'($urandom);
            r_dist  = ($urandom_range(0, 3) == 0);
            load_regs(16'($urandom), 16'($urandom));
            run_txn("rnd", r_we, r_waits, r_rdata, r_dist);
            check_mdrbus(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory-interface stage of the LC-3 datapath; sits directly downstream of the bus and control unit.
- Owns the MAR and MDR registers and converts control-unit memory enables into a req/ack transaction to an external memory with variable wait states.
- Returns read data into MDR and signals completion (memRDY) back to the control FSM.
- Supplies the MDR value toward the Buss tri-state mux.

Parameters:
- TIMEOUT, 16, max cycles in a wait state without mem_ack before the transaction is aborted (legal range 2..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- Buss  input  16  datapath bus; source for MAR/MDR loads.
- ldMAR  input  1  load MAR from Buss.
- ldMDR  input  1  load MDR from Buss (selMDR=0 path).
- selMDR  input  1  1: MDR source is memory (read transaction); 0: MDR source is Buss.
- memEN  input  1  start memory transaction (sampled only in IDLE).
- memWE  input  1  with memEN: 1 = write, 0 = read.
- enaMDR  input  1  drive MDR onto MDRBus.
- MAR  output  16  memory address register.
- MDR  output  16  memory data register.
- MDRBus  output  16  MDR when enaMDR=1, else 16'h0000.
- memRDY  output  1  one-cycle pulse: transaction complete.
- memErr  output  1  sticky timeout flag.
- mem_addr  output  16  address to memory (= MAR while mem_req).
- mem_wdata  output  16  write data (= MDR while mem_req).
- mem_req  output  1  registered request, held until ack or timeout.
- mem_we  output  1  registered write qualifier, valid with mem_req.
- mem_rdata  input  16  read data, valid when mem_ack=1.
- mem_ack  input  1  memory completion strobe.

Behaviour:
- Reset (rst=0, async): MAR=0, MDR=0, mem_req=0, mem_we=0, memRDY=0, memErr=0, wait counter=0, state=IDLE. Takes effect immediately. Aborts any transaction mid-flight; no memRDY is issued for the aborted access.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - ldMAR=1: MAR<=Buss.
  - ldMDR=1 and selMDR=0: MDR<=Buss.
  - memEN=1 and memWE=0: mem_req<=1, mem_we<=0, go RD_WAIT.
  - memEN=1 and memWE=1: mem_req<=1, mem_we<=1, go WR_WAIT.
  - ldMAR and memEN in the same cycle: the request uses the old MAR. Control must load MAR one cycle earlier.
- RD_WAIT:
  - mem_ack=1: MDR<=mem_rdata, mem_req<=0, go DONE.
  - Otherwise count++. When count reaches TIMEOUT-1 without ack: MDR<=16'h0000, memErr<=1, mem_req<=0, go DONE.
- WR_WAIT: same as RD_WAIT, but MDR is not modified on either ack or timeout.
- Ack arriving in the same cycle as timeout: ack wins, memErr is unchanged.
- DONE: memRDY=1 for exactly this cycle, counter cleared, unconditional return to IDLE.
- Minimum transaction latency: memEN sampled at edge N, mem_req high from N; ack at edge N+1 gives memRDY high in cycle N+1..N+2. Three cycles from memEN to return to IDLE.
- ldMAR, ldMDR and memEN are ignored outside IDLE. mem_ack is ignored outside the WAIT states.
- mem_addr and mem_wdata are stable for the whole time mem_req=1.
- memErr is sticky until reset.
- MDRBus is combinational from MDR and enaMDR.

Test Plan:
- Reset mid-read: assert memEN read, drop rst during RD_WAIT -> mem_req=0 immediately, MAR=MDR=0, no memRDY after release.
- Read, zero wait: Buss=16'h3000 with ldMAR, then memEN=1 memWE=0, ack next cycle with rdata=16'hBEEF -> MDR=16'hBEEF, memRDY single pulse, enaMDR=1 gives MDRBus=16'hBEEF.
- Write, 5 wait states: MAR=16'h0040, MDR=16'h1234 via ldMDR/selMDR=0, memEN memWE=1 -> mem_addr=16'h0040, mem_wdata=16'h1234 held 6 cycles, mem_we=1, memRDY after ack.
- Timeout: read with no ack, TIMEOUT=16 -> mem_req drops after 16 cycles, MDR=16'h0000, memErr=1 and remains 1 through a later good read.
- Ack on timeout cycle: ack at cycle TIMEOUT-1 with rdata=16'h00FF -> MDR=16'h00FF, memErr=0.
- Ignored loads: ldMAR with Buss=16'hFFFF during RD_WAIT -> MAR unchanged, mem_addr unchanged.
